// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS x DATA_WIDTH registers with byte-strobed
// writes, per-register read-only status mirroring, SLVERR on RO writes and DECERR
// on out-of-range accesses. Write and read channels run independent FSMs.
module axi4_lite_regbank #(
  parameter int unsigned          NUM_REGS   = 16,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 12,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          awaddr_i,
  input  logic                           awvalid_i,
  output logic                           awready_o,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic                           wvalid_i,
  output logic                           wready_o,
  output logic [1:0]                     bresp_o,
  output logic                           bvalid_o,
  input  logic                           bready_i,
  input  logic [ADDR_WIDTH-1:0]          araddr_i,
  input  logic                           arvalid_i,
  output logic                           arready_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [1:0]                     rresp_o,
  output logic                           rvalid_o,
  input  logic                           rready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]            reg_wr_pulse_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status_i
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS_W;
  localparam int unsigned SEL_W  = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e r_wstate, w_wstate_nxt;
  r_state_e r_rstate, w_rstate_nxt;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  r_aw_held, r_w_held;
  logic [IDX_W-1:0]      r_awidx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic [1:0]            r_bresp;
  logic [NUM_REGS-1:0]   r_wr_pulse;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_aw_hs, w_w_hs, w_commit, w_ar_hs;
  logic [IDX_W-1:0]      w_widx, w_ridx;
  logic [SEL_W-1:0]      w_wsel, w_rsel;
  logic [DATA_WIDTH-1:0] w_wdata, w_rd_word;
  logic [STRB_W-1:0]     w_wstrb;
  logic [1:0]            w_bresp_nxt, w_rresp_nxt;
  logic                  w_unused;

  // Byte-offset address bits carry no information for word-sized registers.
  assign w_unused = ^{awaddr_i[OFFS_W-1:0], araddr_i[OFFS_W-1:0]};

  // A channel captured on an earlier edge is taken from its holding register,
  // otherwise straight from the bus so the commit can happen on the handshake edge.
  assign w_widx  = r_aw_held ? r_awidx : awaddr_i[ADDR_WIDTH-1:OFFS_W];
  assign w_wdata = r_w_held  ? r_wdata : wdata_i;
  assign w_wstrb = r_w_held  ? r_wstrb : wstrb_i;
  assign w_wsel  = w_widx[SEL_W-1:0];
  assign w_ridx  = araddr_i[ADDR_WIDTH-1:OFFS_W];
  assign w_rsel  = w_ridx[SEL_W-1:0];

  assign bresp_o        = r_bresp;
  assign reg_wr_pulse_o = r_wr_pulse;
  assign rdata_o        = r_rdata;
  assign rresp_o        = r_rresp;

  // Write response classification: range first, then read-only protection.
  always_comb begin
    w_bresp_nxt = RESP_OKAY;
    if (32'(w_widx) >= NUM_REGS)  w_bresp_nxt = RESP_DECERR;
    else if (RO_MASK[w_wsel])     w_bresp_nxt = RESP_SLVERR;
  end

  // Write FSM next state, channel readies and commit strobe.
  always_comb begin
    w_wstate_nxt = r_wstate;
    awready_o    = 1'b0;
    wready_o     = 1'b0;
    bvalid_o     = 1'b0;
    w_aw_hs      = 1'b0;
    w_w_hs       = 1'b0;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        awready_o = ~r_aw_held;
        wready_o  = ~r_w_held;
        w_aw_hs   = awvalid_i & ~r_aw_held;
        w_w_hs    = wvalid_i & ~r_w_held;
        w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
        if (w_commit) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  // AW/W holding registers, write response and single-cycle commit pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awidx    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bresp   <= w_bresp_nxt;
        if (w_bresp_nxt == RESP_OKAY) r_wr_pulse[w_wsel] <= 1'b1;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awidx   <= awaddr_i[ADDR_WIDTH-1:OFFS_W];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= wdata_i;
          r_wstrb  <= wstrb_i;
        end
      end
    end
  end

  // Register storage: byte-strobed update on an OKAY commit only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && (w_bresp_nxt == RESP_OKAY)) begin
      for (int unsigned k = 0; k < STRB_W; k++) begin
        if (w_wstrb[k]) r_regs[w_wsel][8*k +: 8] <= w_wdata[8*k +: 8];
      end
    end
  end

  // Read data source: RW storage, live status for RO slots, zero when out of range.
  always_comb begin
    w_rd_word   = '0;
    w_rresp_nxt = RESP_OKAY;
    if (32'(w_ridx) >= NUM_REGS) begin
      w_rresp_nxt = RESP_DECERR;
    end else if (RO_MASK[w_rsel]) begin
      w_rd_word = hw_status_i[32'(w_rsel)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      w_rd_word = r_regs[w_rsel];
    end
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    w_rstate_nxt = r_rstate;
    arready_o    = 1'b0;
    rvalid_o     = 1'b0;
    w_ar_hs      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        arready_o = 1'b1;
        w_ar_hs   = arvalid_i;
        if (arvalid_i) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid_o = 1'b1;
        if (rready_i) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  // Read data/response capture on the AR handshake, held until the R handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_word;
      r_rresp <= w_rresp_nxt;
    end
  end

  // Flattened view of RW registers; RO slots read as zero.
  always_comb begin
    reg_q_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_q_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : r_regs[i];
    end
  end

endmodule
